// File: rtl/s2mm_cmd_arbiter.sv
// Shares one S2MM datamover between two requesters; commands go out one cycle after the grant, and statuses route back combinationally in issue order.
// Backpressure: requesters stall while a command is held or the ID FIFO is full; status stalls while the FIFO is empty or the head requester's status port is not ready.

module sync_fifo #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_vld,
    input  logic [WIDTH-1:0]         push_dat,
    input  logic                     pop_vld,
    output logic [WIDTH-1:0]         head_dat,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_vld)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop_vld)
                rd_ptr <= rd_ptr + AW'(1);
            count <= count + (AW+1)'(push_vld) - (AW+1)'(pop_vld);
        end
    end

    always_ff @(posedge clk) begin
        if (push_vld)
            mem[wr_ptr] <= push_dat;
    end

    assign head_dat = mem[rd_ptr];
    assign empty    = (count == '0);
    assign full     = (count == (AW+1)'(DEPTH));
endmodule

module s2mm_cmd_arbiter #(
    parameter int OUTSTANDING_MAX = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [71:0] s_axis_cmd0_tdata,
    input  logic        s_axis_cmd0_tvalid,
    output logic        s_axis_cmd0_tready,
    input  logic [71:0] s_axis_cmd1_tdata,
    input  logic        s_axis_cmd1_tvalid,
    output logic        s_axis_cmd1_tready,
    output logic [71:0] m_axis_s2mm_cmd_tdata,
    output logic        m_axis_s2mm_cmd_tvalid,
    input  logic        m_axis_s2mm_cmd_tready,
    input  logic [7:0]  s_axis_s2mm_sts_tdata,
    input  logic        s_axis_s2mm_sts_tvalid,
    output logic        s_axis_s2mm_sts_tready,
    output logic [7:0]  m_axis_sts0_tdata,
    output logic        m_axis_sts0_tvalid,
    input  logic        m_axis_sts0_tready,
    output logic [7:0]  m_axis_sts1_tdata,
    output logic        m_axis_sts1_tvalid,
    input  logic        m_axis_sts1_tready,
    output logic [4:0]  outstanding_cnt,
    output logic        err_flag
);
    typedef enum logic {IDLE, ISSUE} state_t;

    state_t      state;
    logic        last_grant;
    logic        cmd_id;
    logic [71:0] cmd_dat;

    logic        gnt0;
    logic        gnt1;
    logic        cmd_rdy;
    logic        cmd_hs;
    logic        sts_hs;
    logic        head_id;
    logic        id_empty;
    logic        id_full;
    logic [$clog2(OUTSTANDING_MAX):0] id_cnt;

    // Tie goes to whoever did not win last; a lone requester always wins.
    assign gnt0    = s_axis_cmd0_tvalid & (~s_axis_cmd1_tvalid | last_grant);
    assign gnt1    = s_axis_cmd1_tvalid & (~s_axis_cmd0_tvalid | ~last_grant);
    // Grant only in IDLE, so a full ID FIFO is the only room limit here.
    assign cmd_rdy = (state == IDLE) & ~id_full & ~rst;

    assign s_axis_cmd0_tready     = cmd_rdy & gnt0;
    assign s_axis_cmd1_tready     = cmd_rdy & gnt1;
    assign m_axis_s2mm_cmd_tvalid = (state == ISSUE) & ~rst;
    assign m_axis_s2mm_cmd_tdata  = cmd_dat;
    assign cmd_hs                 = m_axis_s2mm_cmd_tvalid & m_axis_s2mm_cmd_tready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            cmd_id     <= 1'b0;
            cmd_dat    <= '0;
            err_flag   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (s_axis_cmd0_tready | s_axis_cmd1_tready) begin
                        state      <= ISSUE;
                        cmd_dat    <= gnt0 ? s_axis_cmd0_tdata : s_axis_cmd1_tdata;
                        cmd_id     <= gnt1;
                        last_grant <= gnt1;
                    end
                end
                ISSUE: begin
                    if (cmd_hs)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            if (sts_hs && (!s_axis_s2mm_sts_tdata[7] || (|s_axis_s2mm_sts_tdata[6:4])))
                err_flag <= 1'b1;
        end
    end

    sync_fifo #(
        .WIDTH (1),
        .DEPTH (OUTSTANDING_MAX)
    ) u_id_fifo (
        .clk      (clk),
        .rst      (rst),
        .push_vld (cmd_hs),
        .push_dat (cmd_id),
        .pop_vld  (sts_hs),
        .head_dat (head_id),
        .empty    (id_empty),
        .full     (id_full),
        .count    (id_cnt)
    );

    assign s_axis_s2mm_sts_tready = ~id_empty & ~rst &
                                    (head_id ? m_axis_sts1_tready : m_axis_sts0_tready);
    assign sts_hs             = s_axis_s2mm_sts_tvalid & s_axis_s2mm_sts_tready;
    assign m_axis_sts0_tvalid = s_axis_s2mm_sts_tvalid & ~id_empty & ~head_id & ~rst;
    assign m_axis_sts1_tvalid = s_axis_s2mm_sts_tvalid & ~id_empty & head_id & ~rst;
    assign m_axis_sts0_tdata  = s_axis_s2mm_sts_tdata;
    assign m_axis_sts1_tdata  = s_axis_s2mm_sts_tdata;
    assign outstanding_cnt    = 5'(id_cnt);
endmodule

// File: tb/tb_s2mm_cmd_arbiter.sv
// Directed bench for s2mm_cmd_arbiter with a command/issue-order scoreboard.
module tb_s2mm_cmd_arbiter;
    logic        clk = 1'b0;
    logic        rst;
    logic [71:0] s_axis_cmd0_tdata, s_axis_cmd1_tdata, m_axis_s2mm_cmd_tdata;
    logic        s_axis_cmd0_tvalid, s_axis_cmd0_tready;
    logic        s_axis_cmd1_tvalid, s_axis_cmd1_tready;
    logic        m_axis_s2mm_cmd_tvalid, m_axis_s2mm_cmd_tready;
    logic [7:0]  s_axis_s2mm_sts_tdata, m_axis_sts0_tdata, m_axis_sts1_tdata;
    logic        s_axis_s2mm_sts_tvalid, s_axis_s2mm_sts_tready;
    logic        m_axis_sts0_tvalid, m_axis_sts0_tready;
    logic        m_axis_sts1_tvalid, m_axis_sts1_tready;
    logic [4:0]  outstanding_cnt;
    logic        err_flag;

    always #5 clk = ~clk;

    s2mm_cmd_arbiter #(.OUTSTANDING_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .s_axis_cmd0_tdata(s_axis_cmd0_tdata), .s_axis_cmd0_tvalid(s_axis_cmd0_tvalid),
        .s_axis_cmd0_tready(s_axis_cmd0_tready),
        .s_axis_cmd1_tdata(s_axis_cmd1_tdata), .s_axis_cmd1_tvalid(s_axis_cmd1_tvalid),
        .s_axis_cmd1_tready(s_axis_cmd1_tready),
        .m_axis_s2mm_cmd_tdata(m_axis_s2mm_cmd_tdata), .m_axis_s2mm_cmd_tvalid(m_axis_s2mm_cmd_tvalid),
        .m_axis_s2mm_cmd_tready(m_axis_s2mm_cmd_tready),
        .s_axis_s2mm_sts_tdata(s_axis_s2mm_sts_tdata), .s_axis_s2mm_sts_tvalid(s_axis_s2mm_sts_tvalid),
        .s_axis_s2mm_sts_tready(s_axis_s2mm_sts_tready),
        .m_axis_sts0_tdata(m_axis_sts0_tdata), .m_axis_sts0_tvalid(m_axis_sts0_tvalid),
        .m_axis_sts0_tready(m_axis_sts0_tready),
        .m_axis_sts1_tdata(m_axis_sts1_tdata), .m_axis_sts1_tvalid(m_axis_sts1_tvalid),
        .m_axis_sts1_tready(m_axis_sts1_tready),
        .outstanding_cnt(outstanding_cnt), .err_flag(err_flag)
    );

    typedef struct packed {
        logic        id;
        logic [71:0] dat;
    } cmd_t;

    cmd_t        cmd_q[$];
    logic        issue_q[$];
    logic        exp_err;
    logic [7:0]  gnt_hist, rte_hist;
    int          gnt_n, rte_n;
    int          errors = 0;
    int          checks = 0;

    task automatic chkv(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Scoreboard: counter equals queued IDs; statuses pop IDs in issue order.
    task automatic monitor();
        cmd_t c;
        logic id;
        chkv("cnt", 72'(outstanding_cnt), 72'(issue_q.size()));
        chk1("err_flag", err_flag, exp_err);
        chk1("gnt_onehot", s_axis_cmd0_tready & s_axis_cmd1_tready, 1'b0);
        if (s_axis_s2mm_sts_tvalid && s_axis_s2mm_sts_tready) begin
            chk1("sts_expected", issue_q.size() != 0, 1'b1);
            if (issue_q.size() != 0) begin
                id = issue_q.pop_front();
                chk1("sts_route", id ? m_axis_sts1_tvalid : m_axis_sts0_tvalid, 1'b1);
                chk1("sts_other", id ? m_axis_sts0_tvalid : m_axis_sts1_tvalid, 1'b0);
                chkv("sts_dat", 72'(id ? m_axis_sts1_tdata : m_axis_sts0_tdata), 72'(s_axis_s2mm_sts_tdata));
                rte_hist[rte_n[2:0]] = id;
                rte_n++;
                if (!s_axis_s2mm_sts_tdata[7] || (|s_axis_s2mm_sts_tdata[6:4]))
                    exp_err = 1'b1;
            end
        end
        if (m_axis_s2mm_cmd_tvalid && m_axis_s2mm_cmd_tready) begin
            chk1("cmd_expected", cmd_q.size() != 0, 1'b1);
            if (cmd_q.size() != 0) begin
                c = cmd_q.pop_front();
                chkv("cmd_dat", m_axis_s2mm_cmd_tdata, c.dat);
                issue_q.push_back(c.id);
            end
        end
        if (s_axis_cmd0_tvalid && s_axis_cmd0_tready) begin
            cmd_q.push_back(cmd_t'({1'b0, s_axis_cmd0_tdata}));
            gnt_hist[gnt_n[2:0]] = 1'b0;
            gnt_n++;
        end
        if (s_axis_cmd1_tvalid && s_axis_cmd1_tready) begin
            cmd_q.push_back(cmd_t'({1'b1, s_axis_cmd1_tdata}));
            gnt_hist[gnt_n[2:0]] = 1'b1;
            gnt_n++;
        end
    endtask

    task automatic sample();
        @(negedge clk);
        monitor();
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        cmd_q.delete();
        issue_q.delete();
        exp_err = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        s_axis_cmd0_tvalid = 1'b0;
        s_axis_cmd1_tvalid = 1'b0;
        s_axis_s2mm_sts_tvalid = 1'b0;
        adv();
        clear_model();
        rst = 1'b0;
    endtask

    // One command from requester id, taken straight through (m_axis ready held by caller).
    task automatic issue(input logic id, input logic [71:0] d);
        if (id) begin s_axis_cmd1_tdata = d; s_axis_cmd1_tvalid = 1'b1; end
        else    begin s_axis_cmd0_tdata = d; s_axis_cmd0_tvalid = 1'b1; end
        sample();
        chk1("issue_rdy", id ? s_axis_cmd1_tready : s_axis_cmd0_tready, 1'b1);
        adv();
        s_axis_cmd0_tvalid = 1'b0;
        s_axis_cmd1_tvalid = 1'b0;
        sample();
        adv();
    endtask

    logic [71:0] d_single;

    initial begin
        d_single = {4'h0, 4'h0, 32'h8000_0000, 1'b0, 1'b1, 6'h00, 1'b1, 23'h000100};
        rst = 1'b1;
        s_axis_cmd0_tdata = '0; s_axis_cmd1_tdata = '0;
        s_axis_cmd0_tvalid = 1'b0; s_axis_cmd1_tvalid = 1'b0;
        m_axis_s2mm_cmd_tready = 1'b0;
        s_axis_s2mm_sts_tdata = '0; s_axis_s2mm_sts_tvalid = 1'b0;
        m_axis_sts0_tready = 1'b1; m_axis_sts1_tready = 1'b1;
        clear_model();
        gnt_hist = '0; gnt_n = 0; rte_hist = '0; rte_n = 0;

        // Reset: nothing handshakes while rst is high.
        adv();
        s_axis_cmd0_tvalid = 1'b1;
        s_axis_s2mm_sts_tvalid = 1'b1;
        @(negedge clk);
        chk1("rst_cmd0_rdy", s_axis_cmd0_tready, 1'b0);
        chk1("rst_sts_rdy", s_axis_s2mm_sts_tready, 1'b0);
        chk1("rst_mcmd_vld", m_axis_s2mm_cmd_tvalid, 1'b0);
        adv();
        rst = 1'b0;
        s_axis_cmd0_tvalid = 1'b0;
        s_axis_s2mm_sts_tvalid = 1'b0;
        sample();
        chk1("post_rst_mcmd_vld", m_axis_s2mm_cmd_tvalid, 1'b0);
        chkv("post_rst_cnt", 72'(outstanding_cnt), 72'(0));
        adv();

        // Single request through to status.
        s_axis_cmd0_tdata = d_single;
        s_axis_cmd0_tvalid = 1'b1;
        sample();
        chk1("t1_cmd0_rdy", s_axis_cmd0_tready, 1'b1);
        chk1("t1_cmd1_rdy", s_axis_cmd1_tready, 1'b0);
        adv();
        s_axis_cmd0_tvalid = 1'b0;
        s_axis_cmd0_tdata = '1;
        sample();
        chk1("t1_mcmd_vld", m_axis_s2mm_cmd_tvalid, 1'b1);
        chkv("t1_mcmd_dat", m_axis_s2mm_cmd_tdata, d_single);
        adv();
        sample();
        chkv("t1_hold_dat", m_axis_s2mm_cmd_tdata, d_single);
        adv();
        m_axis_s2mm_cmd_tready = 1'b1;
        sample();
        adv();
        m_axis_s2mm_cmd_tready = 1'b0;
        sample();
        chkv("t1_cnt1", 72'(outstanding_cnt), 72'(1));
        chk1("t1_mcmd_idle", m_axis_s2mm_cmd_tvalid, 1'b0);
        adv();
        s_axis_s2mm_sts_tdata = 8'h80;
        s_axis_s2mm_sts_tvalid = 1'b1;
        sample();
        chk1("t1_sts0_vld", m_axis_sts0_tvalid, 1'b1);
        chk1("t1_sts1_vld", m_axis_sts1_tvalid, 1'b0);
        chk1("t1_sts_rdy", s_axis_s2mm_sts_tready, 1'b1);
        adv();
        s_axis_s2mm_sts_tvalid = 1'b0;
        sample();
        chkv("t1_cnt0", 72'(outstanding_cnt), 72'(0));
        chk1("t1_err", err_flag, 1'b0);
        adv();

        // Contention: round-robin until the ID FIFO fills.
        do_reset();
        gnt_hist = '0; gnt_n = 0; rte_hist = '0; rte_n = 0;
        s_axis_cmd0_tdata = 72'hA0_0000_0000_0000_00A0;
        s_axis_cmd1_tdata = 72'hB1_0000_0000_0000_00B1;
        s_axis_cmd0_tvalid = 1'b1;
        s_axis_cmd1_tvalid = 1'b1;
        m_axis_s2mm_cmd_tready = 1'b1;
        repeat (12) begin
            sample();
            adv();
        end
        sample();
        chkv("t2_gnt_n", 72'(gnt_n), 72'(4));
        chkv("t2_gnt_order", 72'(gnt_hist[3:0]), 72'(4'b1010));
        chkv("t2_cnt4", 72'(outstanding_cnt), 72'(4));
        chk1("t2_full_rdy0", s_axis_cmd0_tready, 1'b0);
        chk1("t2_full_rdy1", s_axis_cmd1_tready, 1'b0);
        adv();
        s_axis_cmd0_tvalid = 1'b0;
        s_axis_cmd1_tvalid = 1'b0;
        s_axis_s2mm_sts_tvalid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            s_axis_s2mm_sts_tdata = 8'h84 + 8'(i);
            sample();
            adv();
        end
        s_axis_s2mm_sts_tvalid = 1'b0;
        sample();
        chkv("t2_route", 72'(rte_hist[3:0]), 72'(4'b1010));
        chkv("t2_drained", 72'(outstanding_cnt), 72'(0));
        adv();

        // In-order routing of 1,0,1.
        rte_hist = '0; rte_n = 0;
        issue(1'b1, 72'h11);
        issue(1'b0, 72'h22);
        issue(1'b1, 72'h33);
        s_axis_s2mm_sts_tvalid = 1'b1;
        s_axis_s2mm_sts_tdata = 8'h81;
        sample();
        chkv("t3_cnt3", 72'(outstanding_cnt), 72'(3));
        chk1("t3_first_sts1", m_axis_sts1_tvalid, 1'b1);
        adv();
        s_axis_s2mm_sts_tdata = 8'h82;
        sample();
        chk1("t3_second_sts0", m_axis_sts0_tvalid, 1'b1);
        adv();
        s_axis_s2mm_sts_tdata = 8'h83;
        sample();
        adv();
        s_axis_s2mm_sts_tvalid = 1'b0;
        sample();
        chkv("t3_route", 72'(rte_hist[2:0]), 72'(3'b101));
        chkv("t3_cnt0", 72'(outstanding_cnt), 72'(0));
        adv();

        // Status backpressure from the head requester.
        issue(1'b0, 72'h44);
        m_axis_sts0_tready = 1'b0;
        s_axis_s2mm_sts_tdata = 8'h80;
        s_axis_s2mm_sts_tvalid = 1'b1;
        sample();
        chk1("t4_stall_rdy", s_axis_s2mm_sts_tready, 1'b0);
        chk1("t4_sts0_vld", m_axis_sts0_tvalid, 1'b1);
        adv();
        sample();
        chkv("t4_cnt_held", 72'(outstanding_cnt), 72'(1));
        adv();
        m_axis_sts0_tready = 1'b1;
        sample();
        chk1("t4_release_rdy", s_axis_s2mm_sts_tready, 1'b1);
        adv();
        s_axis_s2mm_sts_tvalid = 1'b0;
        sample();
        chkv("t4_cnt0", 72'(outstanding_cnt), 72'(0));
        adv();

        // Simultaneous push/pop with an error status.
        issue(1'b0, 72'h55);
        issue(1'b1, 72'h66);
        m_axis_s2mm_cmd_tready = 1'b0;
        s_axis_cmd0_tdata = 72'h77;
        s_axis_cmd0_tvalid = 1'b1;
        sample();
        adv();
        s_axis_cmd0_tvalid = 1'b0;
        m_axis_s2mm_cmd_tready = 1'b1;
        s_axis_s2mm_sts_tdata = 8'h40;
        s_axis_s2mm_sts_tvalid = 1'b1;
        sample();
        chk1("t5_both_mcmd", m_axis_s2mm_cmd_tvalid, 1'b1);
        chk1("t5_both_sts", s_axis_s2mm_sts_tready, 1'b1);
        adv();
        s_axis_s2mm_sts_tvalid = 1'b0;
        sample();
        chkv("t5_cnt2", 72'(outstanding_cnt), 72'(2));
        chk1("t5_err_set", err_flag, 1'b1);
        adv();
        repeat (3) begin
            sample();
            adv();
        end
        sample();
        chk1("t5_err_sticky", err_flag, 1'b1);
        adv();

        // Reset mid-ISSUE with three outstanding.
        issue(1'b1, 72'h88);
        m_axis_s2mm_cmd_tready = 1'b0;
        s_axis_cmd0_tdata = 72'h99;
        s_axis_cmd0_tvalid = 1'b1;
        sample();
        adv();
        s_axis_cmd0_tvalid = 1'b0;
        sample();
        chk1("t6_issue", m_axis_s2mm_cmd_tvalid, 1'b1);
        chkv("t6_cnt3", 72'(outstanding_cnt), 72'(3));
        adv();
        rst = 1'b1;
        m_axis_s2mm_cmd_tready = 1'b1;
        s_axis_s2mm_sts_tdata = 8'h80;
        s_axis_s2mm_sts_tvalid = 1'b1;
        @(negedge clk);
        chk1("t6_rst_mcmd_gate", m_axis_s2mm_cmd_tvalid, 1'b0);
        chk1("t6_rst_sts_gate", s_axis_s2mm_sts_tready, 1'b0);
        adv();
        clear_model();
        rst = 1'b0;
        m_axis_s2mm_cmd_tready = 1'b0;
        sample();
        chkv("t6_cnt0", 72'(outstanding_cnt), 72'(0));
        chk1("t6_mcmd_vld", m_axis_s2mm_cmd_tvalid, 1'b0);
        chk1("t6_err_clr", err_flag, 1'b0);
        chk1("t6_sts_rdy", s_axis_s2mm_sts_tready, 1'b0);
        chk1("t6_sts0_vld", m_axis_sts0_tvalid, 1'b0);
        chk1("t6_sts1_vld", m_axis_sts1_tvalid, 1'b0);
        adv();
        s_axis_s2mm_sts_tvalid = 1'b0;
        m_axis_s2mm_cmd_tready = 1'b1;
        issue(1'b0, 72'hAB);
        s_axis_s2mm_sts_tvalid = 1'b1;
        sample();
        chk1("t6_new_sts0", m_axis_sts0_tvalid, 1'b1);
        adv();
        s_axis_s2mm_sts_tvalid = 1'b0;
        sample();
        chkv("t6_final_cnt", 72'(outstanding_cnt), 72'(0));
        adv();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/s2mm_cmd_arbiter.md
S2MM_CMD_ARBITER -- requirements
Module: s2mm_cmd_arbiter

Interface
REQ-001 Parameter: OUTSTANDING_MAX, default 4, ID-FIFO depth (max commands issued awaiting status); power of two, 2..16.
REQ-002 Port: clk  input  1  sole clock; all logic on rising edge.
REQ-003 Port: rst  input  1  synchronous, active-high reset.
REQ-004 Ports: s_axis_cmd0_tdata/tvalid/tready  in/in/out  72/1/1  requester 0 S2MM command (datamover 72-bit format).
REQ-005 Ports: s_axis_cmd1_tdata/tvalid/tready  in/in/out  72/1/1  requester 1 S2MM command.
REQ-006 Ports: m_axis_s2mm_cmd_tdata/tvalid/tready  out/out/in  72/1/1  command to datamover.
REQ-007 Ports: s_axis_s2mm_sts_tdata/tvalid/tready  in/in/out  8/1/1  datamover status.
REQ-008 Ports: m_axis_sts0_tdata/tvalid/tready  out/out/in  8/1/1  status returned to requester 0.
REQ-009 Ports: m_axis_sts1_tdata/tvalid/tready  out/out/in  8/1/1  status returned to requester 1.
REQ-010 Port: outstanding_cnt  output  5  commands accepted by datamover with status not yet returned.
REQ-011 Port: err_flag  output  1  sticky status-error indicator.

Function
REQ-012 FSM states: IDLE (no command held), ISSUE (command held on m_axis_s2mm_cmd, tvalid=1).
REQ-013 IDLE->ISSUE when a requester is granted; ISSUE->IDLE on m_axis_s2mm_cmd_tvalid & tready; no other transitions.
REQ-014 Grant in IDLE only, and only when outstanding_cnt + (ISSUE?1:0) < OUTSTANDING_MAX (i.e. ID FIFO has room counting the held command).
REQ-015 Arbitration: single valid requester wins; both valid -> requester not granted last wins (round-robin); last_grant resets to 1 so requester 0 wins first tie.
REQ-016 s_axis_cmdN_tready = IDLE & room & grantN (combinational from tvalids); asserted for exactly the handshake cycle.
REQ-017 Requester handshake in cycle N -> m_axis_s2mm_cmd_tdata = captured tdata, tvalid=1 from cycle N+1; tdata stable while tvalid & ~tready.
REQ-018 On datamover command handshake, push granted requester ID (1 bit) into ID FIFO; outstanding_cnt +1.
REQ-019 s_axis_s2mm_sts_tready = FIFO not empty & m_axis_stsK_tready, K = FIFO head ID; stall (tready=0) when FIFO empty.
REQ-020 m_axis_stsK_tvalid = s_axis_s2mm_sts_tvalid & FIFO not empty & head==K; other requester's tvalid=0; tdata passes through combinationally to both.
REQ-021 On status handshake, pop FIFO; outstanding_cnt -1.
REQ-022 Push and pop in same cycle: outstanding_cnt unchanged, FIFO order preserved; statuses returned strictly in command-issue order.
REQ-023 Status error: tdata[7]==0 (not OKAY) or any of tdata[6:4] set on handshake -> err_flag=1 next cycle, held until reset.
REQ-024 Command tdata not inspected or modified; tags not checked.

Reset
REQ-025 rst sampled high on clk edge: state=IDLE, last_grant=1, FIFO empty, outstanding_cnt=0, err_flag=0, all tvalid/tready outputs 0 next cycle.
REQ-026 Reset mid-ISSUE or with outstanding commands: held command and pending IDs discarded; no status routed until new command issued.
REQ-027 While rst high, no handshakes complete on any interface.

Verification
REQ-028 Single request: cmd0 tvalid with tdata=72'h0_0_80000000_0_1_00_1_000100 -> cmd0_tready 1 cycle, m_cmd_tvalid next cycle with same tdata; ready=1 -> outstanding_cnt=1; sts 8'h80 -> sts0_tvalid, cnt=0, err_flag=0.
REQ-029 Contention: cmd0 and cmd1 both held valid, m_cmd_tready=1, sts stalled -> grant order 0,1,0,1; stops after 4 with cnt=4; further tvalids see tready=0.
REQ-030 In-order routing: issue 1,0,1; return sts 8'h81,8'h82,8'h83 -> sts1 gets 81, sts0 gets 82, sts1 gets 83; cnt 3->0.
REQ-031 Backpressure: head ID=0, sts0_tready=0, sts_tvalid=1 -> s2mm_sts_tready=0, FIFO unchanged; sts0_tready=1 -> pop same cycle.
REQ-032 Error/simultaneous: cnt=2, command handshake and status 8'h40 same cycle -> cnt stays 2, err_flag=1 next cycle and stays 1 until rst.
REQ-033 Reset mid-operation: cnt=3, state ISSUE, rst pulsed 1 cycle -> cnt=0, m_cmd_tvalid=0, err_flag=0; sts_tvalid then gives sts_tready=0.
